// File: rtl/aes_spi_encrypt.sv
// SPI-attached AES-128/AES-256 encryption engine.
// Serial key/plaintext/readout frames feed an iterative one-round-per-clock AES core.
module aes_spi_encrypt (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sclk,
  input  logic sdi,
  output logic sdo
);
  localparam int unsigned CntW = 9;
  localparam logic [CntW-1:0] Len128 = CntW'(130);
  localparam logic [CntW-1:0] Len256 = CntW'(258);
  localparam logic [3:0] Nr128 = 4'd10;
  localparam logic [3:0] Nr256 = 4'd14;

  typedef enum logic [1:0] {KEY, MSG, BUSY, READ} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Combinational S-box: GF(2^8) inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, t, inv;
    x2  = gmul(x, x);
    x3  = gmul(x2, x);
    t   = gmul(x3, x3);
    x12 = gmul(t, t);
    t   = gmul(x12, x3);
    t   = gmul(t, t);
    t   = gmul(t, t);
    t   = gmul(t, t);
    t   = gmul(t, t);
    t   = gmul(t, x12);
    inv = gmul(t, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]      cs_sync, sclk_sync, sdi_sync;
  logic            cs_q, sclk_q;
  logic            cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;
  logic            frame_act, frame_ok, frame_done_c;
  logic [CntW-1:0] bit_cnt, cnt_nx_c, frame_len_c;
  logic [1:0]      hdr, hdr_nx_c;
  logic [255:0]    data, data_nx_c;
  state_t          state;
  logic            mode256, rot_step, use_rot_c, last_c, rd_bit_c;
  logic [255:0]    key_reg, kw, kw_nx_c;
  logic [127:0]    pt, st, ct, sb_c, sr_c, mc_c, round_out_c;
  logic [31:0]     kt_c, ks_c, tf_c, w0_c, w1_c, w2_c, w3_c;
  logic [7:0]      rcon;
  logic [3:0]      rnd, nr_c;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      sdi_sync  <= 2'b00;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], sclk};
      sdi_sync  <= {sdi_sync[0], sdi};
      cs_q      <= cs_sync[1];
      sclk_q    <= sclk_sync[1];
    end
  end

  assign cs_fall_c   = cs_q & ~cs_sync[1];
  assign cs_rise_c   = ~cs_q & cs_sync[1];
  assign sclk_rise_c = ~sclk_q & sclk_sync[1];
  assign sclk_fall_c = sclk_q & ~sclk_sync[1];

  // Next shift-register contents; an sclk edge in the cs-rise cycle is folded in first.
  always_comb begin
    frame_len_c = (state == KEY && hdr == 2'b10) ? Len256 : Len128;
    cnt_nx_c    = bit_cnt;
    hdr_nx_c    = hdr;
    data_nx_c   = data;
    if (frame_act && sclk_rise_c) begin
      if (bit_cnt != '1) cnt_nx_c = bit_cnt + CntW'(1);
      if (bit_cnt < CntW'(2)) hdr_nx_c = {hdr[0], sdi_sync[1]};
      else if (bit_cnt < frame_len_c) data_nx_c = {data[254:0], sdi_sync[1]};
    end
    frame_done_c = frame_act && frame_ok && cs_rise_c && (cnt_nx_c >= frame_len_c);
  end

  // Frame capture: bit counter, header and payload shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_act <= 1'b0;
      frame_ok  <= 1'b0;
      bit_cnt   <= '0;
      hdr       <= 2'b00;
      data      <= '0;
    end else if (cs_fall_c) begin
      frame_act <= 1'b1;
      frame_ok  <= (state != BUSY);
      bit_cnt   <= '0;
    end else if (frame_act) begin
      bit_cnt <= cnt_nx_c;
      hdr     <= hdr_nx_c;
      data    <= data_nx_c;
      if (cs_rise_c) frame_act <= 1'b0;
    end
  end

  // One AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  for (genvar b = 0; b < 16; b++) begin : g_sbox_state
    assign sb_c[127-8*b -: 8] = sbox(st[127-8*b -: 8]);
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    sr_c = '0;
    mc_c = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_c[127-8*(4*c+r) -: 8] = sb_c[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr_c[127-32*c -: 8];
      a1 = sr_c[119-32*c -: 8];
      a2 = sr_c[111-32*c -: 8];
      a3 = sr_c[103-32*c -: 8];
      mc_c[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_c[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_c[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_c[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign nr_c        = mode256 ? Nr256 : Nr128;
  assign last_c      = (rnd == nr_c);
  assign round_out_c = (last_c ? sr_c : mc_c) ^ kw[255:128];

  // Forward key expansion: kw[255:128] is the current round key.
  assign kt_c = mode256 ? kw[31:0] : kw[159:128];
  for (genvar i = 0; i < 4; i++) begin : g_sbox_key
    assign ks_c[8*i +: 8] = sbox(kt_c[8*i +: 8]);
  end
  assign use_rot_c = !mode256 || rot_step;
  assign tf_c      = use_rot_c ? ({ks_c[23:0], ks_c[31:24]} ^ {rcon, 24'h000000}) : ks_c;
  assign w0_c      = kw[255:224] ^ tf_c;
  assign w1_c      = kw[223:192] ^ w0_c;
  assign w2_c      = kw[191:160] ^ w1_c;
  assign w3_c      = kw[159:128] ^ w2_c;
  assign kw_nx_c   = mode256 ? {kw[127:0], w0_c, w1_c, w2_c, w3_c}
                             : {w0_c, w1_c, w2_c, w3_c, 128'h0};

  // Readout bit for the current bit position: two zero header bits, then ciphertext MSB first.
  assign rd_bit_c = (bit_cnt >= CntW'(2) && bit_cnt < Len128) ? ct[7'(CntW'(129) - bit_cnt)] : 1'b0;

  // Frame sequencer, round iteration and serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= KEY;
      sdo      <= 1'b0;
      mode256  <= 1'b0;
      key_reg  <= '0;
      pt       <= '0;
      ct       <= '0;
      st       <= '0;
      kw       <= '0;
      rcon     <= 8'h00;
      rot_step <= 1'b0;
      rnd      <= '0;
    end else begin
      case (state)
        KEY: if (frame_done_c) begin
          mode256 <= (hdr == 2'b10);
          key_reg <= (hdr == 2'b10) ? data_nx_c : {data_nx_c[127:0], 128'h0};
          state   <= MSG;
        end
        MSG: if (frame_done_c) begin
          pt       <= data_nx_c[127:0];
          kw       <= key_reg;
          rcon     <= 8'h01;
          rot_step <= 1'b1;
          rnd      <= '0;
          state    <= BUSY;
        end
        BUSY: begin
          st       <= (rnd == 4'd0) ? (pt ^ kw[255:128]) : round_out_c;
          kw       <= kw_nx_c;
          rot_step <= ~rot_step;
          rnd      <= rnd + 4'd1;
          if (use_rot_c) rcon <= xtime(rcon);
          if (last_c) begin
            ct    <= round_out_c;
            state <= READ;
          end
        end
        READ: if (frame_done_c) begin
          key_reg <= '0;
          state   <= KEY;
        end
        default: state <= KEY;
      endcase

      if (cs_rise_c || !(frame_act && frame_ok && state == READ)) sdo <= 1'b0;
      else if (sclk_fall_c) sdo <= rd_bit_c;
    end
  end
endmodule

// File: tb/tb_aes_spi_encrypt.sv
// Bench for aes_spi_encrypt: frame-level host model with FIPS-197 reference vectors.
module tb_aes_spi_encrypt;
  localparam int HALF = 8;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic sdo;

  int checks = 0;
  int errors = 0;
  bit smp = 1'b0;
  bit rd_active = 1'b0;
  logic exp_bit = 1'b0;
  int bit_idx = 0;
  int since_rd = 0;
  logic [129:0] cap = '0;

  // Frame-level host model: which frame the engine expects and what it must return.
  int m_phase = 0;
  bit m_256 = 1'b0;
  logic [255:0] m_key = '0;
  logic [127:0] m_pt = '0;
  logic [127:0] m_ct = '0;

  aes_spi_encrypt dut (
    .clk (clk),
    .rst (rst),
    .cs  (cs),
    .sclk(sclk),
    .sdi (sdi),
    .sdo (sdo)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] aes_ref(input bit is256, input logic [255:0] key, input logic [127:0] p);
    if (!is256 && key == {KEY128, 128'h0} && p == PT) return CT128;
    if (is256 && key == KEY256 && p == PT) return CT256;
    return 'x;
  endfunction

  task automatic model_frame(input int n, input logic [257:0] bits, input bit ignored);
    logic [1:0] h;
    int need;
    if (ignored || n < 2) return;
    h = bits[n-1 -: 2];
    case (m_phase)
      0: begin
        need = (h == 2'b10) ? 258 : 130;
        if (n >= need) begin
          m_256 = (h == 2'b10);
          m_key = m_256 ? bits[255:0] : {bits[127:0], 128'h0};
          m_phase = 1;
        end
      end
      1: if (n >= 130) begin
        m_pt = bits[127:0];
        m_ct = aes_ref(m_256, m_key, m_pt);
        m_phase = 2;
      end
      default: if (n >= 130) m_phase = 0;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one SPI mode-0 frame; on readout frames request an sdo sample before each rise.
  task automatic spi_frame(input int n, input logic [257:0] bits, input bit rd,
                           input logic [127:0] ct, input int gap);
    cs = 1'b0;
    rd_active = rd;
    tick(HALF);
    for (int k = 0; k < n; k++) begin
      sdi = bits[n-1-k];
      tick(HALF - 1);
      if (rd) begin
        bit_idx = k;
        exp_bit = (k >= 2 && k < 130) ? ct[129-k] : 1'b0;
        smp = 1'b1;
      end
      tick(1);
      smp = 1'b0;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    cs = 1'b1;
    sdi = 1'b0;
    tick(gap);
    rd_active = 1'b0;
  endtask

  task automatic send(input int n, input logic [257:0] bits, input int gap);
    model_frame(n, bits, 1'b0);
    spi_frame(n, bits, 1'b0, '0, gap);
  endtask

  task automatic readout(input bit ignored, input int gap, input logic [127:0] pin);
    logic [127:0] exp_ct;
    exp_ct = (!ignored && m_phase == 2) ? m_ct : 128'h0;
    model_frame(130, '0, ignored);
    spi_frame(130, '0, 1'b1, exp_ct, gap);
    @(posedge clk);
    checks++;
    if (cap[127:0] !== pin) begin
      errors++;
      $display("FAIL readout_word got=%h exp=%h", cap[127:0], pin);
    end
  endtask

  // Compare process: sdo bit samples in readout frames, sdo==0 everywhere else.
  always @(negedge clk) begin
    if (rd_active) since_rd = 0;
    else if (since_rd < 8) since_rd = since_rd + 1;
    if (smp) begin
      checks++;
      cap = {cap[128:0], sdo};
      if (sdo !== exp_bit) begin
        errors++;
        $display("FAIL sdo_bit k=%0d got=%b exp=%b t=%0t", bit_idx, sdo, exp_bit, $time);
      end
    end else if (!rd_active && !rst && since_rd >= 4) begin
      checks++;
      if (sdo !== 1'b0) begin
        errors++;
        $display("FAIL sdo_idle got=%b exp=0 t=%0t", sdo, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(4);
    rst = 1'b0;
    tick(10);

    // AES-128 C.1
    send(130, {2'b00, KEY128}, 6);
    send(130, {2'b00, PT}, 30);
    readout(1'b0, 8, CT128);

    // AES-256 C.3, back-to-back
    send(258, {2'b10, KEY256}, 6);
    send(130, {2'b00, PT}, 30);
    readout(1'b0, 8, CT256);

    // Idle sclk with cs high, then a short frame in MSG
    send(130, {2'b00, KEY128}, 6);
    for (int i = 0; i < 20; i++) begin
      sdi = 1'($urandom_range(0, 1));
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    sdi = 1'b0;
    send(60, {2'b00, PT}, 6);
    send(130, {2'b00, PT}, 30);
    readout(1'b0, 8, CT128);

    // Reset during BUSY, then a full C.1 sequence
    send(130, {2'b00, KEY128}, 6);
    send(130, {2'b00, PT}, 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_phase = 0;
    tick(10);
    send(130, {2'b00, KEY128}, 6);
    send(130, {2'b00, PT}, 30);
    readout(1'b0, 8, CT128);

    // Frame started during BUSY is ignored
    send(130, {2'b00, KEY128}, 6);
    send(130, {2'b00, PT}, 2);
    readout(1'b1, 30, 128'h0);
    readout(1'b0, 8, CT128);

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
